// File: rtl/pair_step_checker.sv
// Consumer-side checker for the saturating (x, y) step-counter pair stream.
// Optional macro PAIR_CHK_RECOVER_EN: errors pulse and the shadow resyncs instead of latching.
module pair_step_checker #(
  parameter int WIDTH  = 11,
  parameter int STEP   = 2,
  parameter int LIMIT  = 200,
  parameter int INIT_X = 2,
  parameter int INIT_Y = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_x,
  input  logic [WIDTH-1:0] obs_y,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             sat,
  output logic [7:0]       step_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, SAT, ERR} state_t;

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LIMIT_W  = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] INIT_X_W = WIDTH'(INIT_X);
  localparam logic [WIDTH-1:0] INIT_Y_W = WIDTH'(INIT_Y);
  localparam logic [WIDTH-1:0] DIFF_W   = INIT_X_W - INIT_Y_W;

  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             sat_q, sat_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] shx_q, shx_d, shy_q, shy_d;

  logic [WIDTH-1:0] diff, exp_x, exp_y;
  logic [2:0]       fail_code;
  logic             obs_hi;

  // Check priority: forbidden pair, then difference invariant, then state rule.
  always_comb begin
    diff      = obs_x - obs_y;
    exp_x     = shx_q + STEP_W;
    exp_y     = shy_q + STEP_W;
    obs_hi    = (obs_x >= LIMIT_W);
    fail_code = 3'd0;
    if (obs_x == WIDTH'(4) && obs_y == '0)
      fail_code = 3'd4;
    else if (diff != DIFF_W)
      fail_code = 3'd3;
    else begin
      case (state_q)
        IDLE:    if (obs_x != INIT_X_W || obs_y != INIT_Y_W) fail_code = 3'd1;
        RUN:     if (obs_x != exp_x || obs_y != exp_y)       fail_code = 3'd2;
        SAT:     if (obs_x != shx_q || obs_y != shy_q)       fail_code = 3'd2;
        default: fail_code = 3'd0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    sat_d      = sat_q;
    step_cnt_d = step_cnt_q;
    shx_d      = shx_q;
    shy_d      = shy_q;
    if (obs_valid && state_q != ERR) begin
      if (fail_code != 3'd0) begin
        err_d      = 1'b1;
        err_code_d = fail_code;
`ifdef PAIR_CHK_RECOVER_EN
        shx_d   = obs_x;
        shy_d   = obs_y;
        state_d = obs_hi ? SAT : RUN;
        if (obs_hi) sat_d = 1'b1;
`else
        state_d = ERR;
`endif
      end else begin
        err_d      = 1'b0;
        err_code_d = 3'd0;
        // A passing SAT sample equals the shadow, so only IDLE/RUN move it.
        if (state_q != SAT) begin
          shx_d   = obs_x;
          shy_d   = obs_y;
          state_d = obs_hi ? SAT : RUN;
          if (obs_hi) sat_d = 1'b1;
          if (state_q == RUN && step_cnt_q != 8'hFF) step_cnt_d = step_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      sat_q      <= 1'b0;
      step_cnt_q <= 8'd0;
      shx_q      <= '0;
      shy_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      sat_q      <= sat_d;
      step_cnt_q <= step_cnt_d;
      shx_q      <= shx_d;
      shy_q      <= shy_d;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
  assign sat      = sat_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_pair_step_checker.sv
// Bench for pair_step_checker: vector table, long saturation run, and random
// stimulus against a rule-level reference model.
module tb_pair_step_checker;
  localparam int WIDTH  = 11;
  localparam int STEP   = 2;
  localparam int LIMIT  = 200;
  localparam int INIT_X = 2;
  localparam int INIT_Y = 1;
  localparam int MASK   = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst, obs_valid;
  logic [WIDTH-1:0] obs_x, obs_y;
  logic             err, sat;
  logic [2:0]       err_code;
  logic [7:0]       step_cnt;

  always #5 clk = ~clk;

  pair_step_checker #(.WIDTH(WIDTH), .STEP(STEP), .LIMIT(LIMIT), .INIT_X(INIT_X), .INIT_Y(INIT_Y)) dut (
    .clk(clk), .rst(rst), .obs_valid(obs_valid), .obs_x(obs_x), .obs_y(obs_y),
    .err(err), .err_code(err_code), .sat(sat), .step_cnt(step_cnt)
  );

  typedef struct {
    bit r; bit v; int x; int y;
    bit e; int c; bit s; int n;
  } vec_t;
  vec_t tbl[$];

  int tests = 0;
  int fails = 0;

  // Reference model: tracks the producer's expected next pair and the outputs.
  bit m_err, m_sat, m_started, m_hold, m_dead;
  int m_code, m_cnt, m_x, m_y;

  task automatic add(input bit r, input bit v, input int x, input int y,
                     input bit e, input int c, input bit s, input int n);
    vec_t t;
    t.r = r; t.v = v; t.x = x; t.y = y; t.e = e; t.c = c; t.s = s; t.n = n;
    tbl.push_back(t);
  endtask

  task automatic drive(input bit r, input bit v, input int x, input int y);
    rst = r; obs_valid = v; obs_x = WIDTH'(x); obs_y = WIDTH'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input bit e, input int c, input bit s, input int n);
    tests++;
    if (err !== e || err_code !== 3'(c) || sat !== s || step_cnt !== 8'(n)) begin
      fails++;
      $display("FAIL %s: got err=%0b code=%0d sat=%0b cnt=%0d, expected err=%0b code=%0d sat=%0b cnt=%0d",
               name, err, err_code, sat, step_cnt, e, c, s, n);
    end
  endtask

  task automatic next_pair(output int nx, output int ny);
    if (!m_started)  begin nx = INIT_X; ny = INIT_Y; end
    else if (m_hold) begin nx = m_x; ny = m_y; end
    else begin nx = (m_x + STEP) & MASK; ny = (m_y + STEP) & MASK; end
  endtask

  task automatic model(input bit r, input bit v, input int x, input int y);
    int code, nx, ny;
    if (r) begin
      m_err = 0; m_code = 0; m_sat = 0; m_cnt = 0;
      m_started = 0; m_hold = 0; m_dead = 0; m_x = 0; m_y = 0;
      return;
    end
    if (!v || m_dead) return;
    next_pair(nx, ny);
    if (x == 4 && y == 0)                                   code = 4;
    else if (((x - y) & MASK) != ((INIT_X - INIT_Y) & MASK)) code = 3;
    else if (x != nx || y != ny)                             code = m_started ? 2 : 1;
    else                                                     code = 0;
    if (code == 0) begin
      if (m_started && !m_hold) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_err = 0; m_code = 0;
    end else begin
      m_err = 1; m_code = code;
`ifndef PAIR_CHK_RECOVER_EN
      m_dead = 1;
      return;
`endif
    end
    m_started = 1; m_x = x; m_y = y;
    m_hold = (x >= LIMIT);
    if (m_hold) m_sat = 1;
  endtask

  initial begin
    rst = 1'b1; obs_valid = 1'b0; obs_x = '0; obs_y = '0;

    // Init mismatch, then ignored follow-ups (sticky) or resync (recovery).
    add(1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 4, 3,   1, 1, 0, 0);
`ifndef PAIR_CHK_RECOVER_EN
    add(0, 1, 6, 5,   1, 1, 0, 0);
    add(0, 1, 2, 1,   1, 1, 0, 0);
`else
    add(0, 1, 6, 5,   0, 0, 0, 1);
`endif
    // Step mismatch after a good run to (10,9).
    add(1, 1, 2, 1,   0, 0, 0, 0);
    add(0, 1, 2, 1,   0, 0, 0, 0);
    add(0, 1, 4, 3,   0, 0, 0, 1);
    add(0, 1, 6, 5,   0, 0, 0, 2);
    add(0, 1, 8, 7,   0, 0, 0, 3);
    add(0, 1, 10, 9,  0, 0, 0, 4);
    add(0, 1, 14, 13, 1, 2, 0, 4);
    // Forbidden pair outranks the difference and step checks.
    add(1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 2, 1,   0, 0, 0, 0);
    add(0, 1, 4, 0,   1, 4, 0, 0);
    // Difference break.
    add(1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 2, 1,   0, 0, 0, 0);
    add(0, 1, 4, 3,   0, 0, 0, 1);
    add(0, 1, 6, 4,   1, 3, 0, 1);
    // Idle gap between (6,5) and (8,7), then reset beats a valid sample.
    add(1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 2, 1,   0, 0, 0, 0);
    add(0, 1, 4, 3,   0, 0, 0, 1);
    add(0, 1, 6, 5,   0, 0, 0, 2);
    for (int i = 0; i < 10; i++) add(0, 0, 4, 0, 0, 0, 0, 2);
    add(0, 1, 8, 7,   0, 0, 0, 3);
    add(1, 1, 10, 9,  0, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 0, 0);
`ifdef PAIR_CHK_RECOVER_EN
    add(0, 1, 2, 1,   0, 0, 0, 0);
    add(0, 1, 4, 3,   0, 0, 0, 1);
    add(0, 1, 8, 7,   1, 2, 0, 1);
    add(0, 1, 10, 9,  0, 0, 0, 2);
`endif

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].x, tbl[i].y);
      check($sformatf("vec%0d", i), tbl[i].e, tbl[i].c, tbl[i].s, tbl[i].n);
    end

    // Full run to saturation, hold, then an illegal step out of SAT.
    drive(1, 0, 0, 0);
    for (int k = 0; k < 100; k++) begin
      drive(0, 1, 2 + 2 * k, 1 + 2 * k);
      check("run", 0, 0, (2 + 2 * k) >= LIMIT, k);
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 200, 199);
      check("hold", 0, 0, 1, 99);
    end
    drive(0, 1, 202, 201);
    check("sat_step", 1, 2, 1, 99);
`ifndef PAIR_CHK_RECOVER_EN
    drive(0, 1, 200, 199);
    check("sat_sticky", 1, 2, 1, 99);
`endif

    // Randomized stream, mostly legal, checked against the model.
    model(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("rand_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      int x, y, nx, ny, sel;
      r = ($urandom_range(99) < (m_err ? 15 : 1));
      v = ($urandom_range(9) < 8);
      next_pair(nx, ny);
      sel = $urandom_range(99);
      if (sel < 96)      begin x = nx; y = ny; end
      else if (sel < 97) begin x = 4; y = 0; end
      else if (sel < 98) begin x = $urandom_range(MASK); y = (x - 1) & MASK; end
      else if (sel < 99) begin x = nx; y = (ny + 1) & MASK; end
      else               begin x = $urandom_range(MASK); y = $urandom_range(MASK); end
      model(r, v, x, y);
      drive(r, v, x, y);
      check("rand", m_err, m_code, m_sat, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pair_step_checker.md
Name: pair_step_checker

Overview:
- Consumer-side checker for the (x, y) pair stream produced by the saturating step-counter benchmark.
- Keeps a shadow model of the producer and samples the observed pair on each valid cycle.
- Flags any departure from the init values, the step/hold rule, the x-y difference invariant, or the forbidden pair (x==4, y==0).
- Sits beside the producer in the envinv harness; outputs feed property-mining traces.

Parameters:
- WIDTH, 11, bit width of x and y.
- STEP, 2, per-cycle increment while below LIMIT.
- LIMIT, 200, x threshold; at or above it the pair holds.
- INIT_X, 2, expected first x after reset.
- INIT_Y, 1, expected first y after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- obs_valid  input  1  obs_x/obs_y carry a sample this cycle.
- obs_x  input  WIDTH  observed x.
- obs_y  input  WIDTH  observed y.
- err  output  1  error flag (sticky unless recovery compiled in).
- err_code  output  3  0 none, 1 init mismatch, 2 step/hold mismatch, 3 difference break, 4 forbidden pair.
- sat  output  1  an accepted sample had x >= LIMIT.
- step_cnt  output  8  count of accepted increment transitions, saturates at 255.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. While rst is high at a clk edge: state=IDLE, err=0, err_code=0, sat=0, step_cnt=0, shadow regs=0.
- All outputs are registered. A sample on edge N is reflected in the outputs after edge N. Cycles with obs_valid=0 change nothing.
- Checks run in this priority order; the first failing check sets err_code:
  - 4: obs_x==4 and obs_y==0.
  - 3: (obs_x - obs_y) mod 2^WIDTH != (INIT_X - INIT_Y) mod 2^WIDTH.
  - 2 or 1: state-dependent check, defined below.
- IDLE:
  - First valid sample must equal (INIT_X, INIT_Y); otherwise code 1.
  - On pass: load shadow, go to RUN, or to SAT if INIT_X >= LIMIT.
- RUN:
  - Expected sample = shadow + STEP for both x and y, mod 2^WIDTH.
  - On mismatch: code 2.
  - On pass: update shadow and increment step_cnt. If the new x >= LIMIT, set sat=1 and go to SAT.
- SAT:
  - Expected sample = shadow unchanged.
  - Any change: code 2.
  - sat stays 1; step_cnt frozen.
- ERR:
  - Entered on any failure; err=1 and err_code latched.
  - Without the recovery feature, ERR is absorbing until rst and further samples are ignored.
- Compare semantics: x < LIMIT is an unsigned compare.
- Reset mid-run: reset wins over a simultaneous obs_valid; that sample is discarded.

Optional Feature:
- Macro: PAIR_CHK_RECOVER_EN.
- Defined:
  - A failing sample still sets err=1 and err_code for exactly one cycle.
  - The shadow then resyncs to the observed pair, and state becomes RUN or SAT according to obs_x vs LIMIT.
  - On the next passing sample, err and err_code return to 0.
  - step_cnt is not cleared.
- Undefined: errors are sticky as described above.

Test Plan:
- Reset, then valid samples (2,1),(4,3),…,(200,199) on consecutive cycles, then 5 cycles of (200,199) -> err=0, sat=1 after sample (200,199), step_cnt=99, step_cnt stays 99.
- Reset, first sample (4,3) -> err=1, err_code=1 the cycle after; later samples ignored.
- After a good run to (10,9), feed (14,13) -> err_code=2. In SAT at (200,199), feed (202,201) -> err_code=2.
- After (2,1), feed (4,0) -> err_code=4 (priority over 3 and 2). Feed (6,4) after (4,3) -> err_code=3.
- obs_valid low for 10 cycles between (6,5) and (8,7) -> no error, step_cnt=3. Assert rst coincident with a valid sample -> all outputs 0 the next cycle.
- With PAIR_CHK_RECOVER_EN: (2,1),(4,3),(8,7),(10,9) -> err pulses 1 for one cycle with code 2, then 0; step_cnt=2.
